ifu_pc_gen: RTL and testbench

Parametrised fetch-PC generator for the IFU, replacing the fixed 32-bit PC counter. It holds the fetch PC, offers it to instruction memory through a valid/ready handshake, limits outstanding fetches, and accepts prioritised redirects (trap over branch). It tags each issued PC with an epoch so the IFU can squash stale responses. Sits between the BRANCH/EXU redirect sources and the IFU memory request port.

---
 rtl/ifu_pkg.sv | 8 +
 rtl/ifu_outst_cnt.sv | 19 +
 rtl/ifu_pc_gen.sv | 80 ++++++++
 tb/tb_ifu_pc_gen.sv | 122 ++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU defaults, epoch tag type and redirect-source encoding.
package ifu_pkg;
    localparam logic [31:0] DEF_RST_PC     = 32'h8000_0000;
    localparam int          DEF_INST_BYTES = 4;
    localparam int          DEF_EPOCH_W    = 2;
    typedef logic [DEF_EPOCH_W-1:0] epoch_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_TRAP, SRC_BRANCH} redir_src_e;
endpackage

// File: rtl/ifu_outst_cnt.sv
// ifu_outst_cnt: up/down saturating outstanding-fetch counter with full flag.
module ifu_outst_cnt #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full
);
    localparam int CW = $clog2(MAX + 1);
    logic [CW-1:0] r_cnt;
    assign o_full = r_cnt == CW'(MAX);
    // a response with nothing outstanding is dropped rather than underflowing
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= r_cnt + CW'(i_inc && !o_full) - CW'(i_dec && r_cnt != '0);
    end
endmodule

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: fetch-PC generator with valid/ready issue, outstanding limit, trap-over-branch redirects and epoch tags.
// Define PC_GEN_MISALIGN_CHK_EN to align misaligned redirect targets and pulse misalign_err.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RST_PC     = XLEN'(DEF_RST_PC),
    parameter int              INST_BYTES = DEF_INST_BYTES,
    parameter int              EPOCH_W    = DEF_EPOCH_W,
    parameter int              MAX_OUTST  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_target,
    input  logic               BRANCH_PCSrc,
    input  logic [XLEN-1:0]    BRANCH_branch_target,
    input  logic               fetch_ready,
    input  logic               resp_valid,
    output logic               fetch_valid,
    output logic [XLEN-1:0]    IFU_o_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               pc_change,
    output logic               misalign_err
);
    redir_src_e         w_src;
    logic [XLEN-1:0]    w_target, w_load;
    logic               w_fire, w_full, w_mis;
    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_pc_change, r_misalign;

    ifu_outst_cnt #(.MAX(MAX_OUTST)) u_outst (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_fire),
        .i_dec  (resp_valid),
        .o_full (w_full)
    );

    assign fetch_valid  = !w_full;
    assign w_fire       = fetch_valid && fetch_ready;
    assign IFU_o_pc     = r_pc;
    assign fetch_epoch  = r_epoch;
    assign pc_change    = r_pc_change;
    assign misalign_err = r_misalign;

    always_comb begin
        w_src    = trap_valid ? SRC_TRAP : BRANCH_PCSrc ? SRC_BRANCH : SRC_NONE;
        w_target = trap_valid ? trap_target : BRANCH_branch_target;
    end

`ifdef PC_GEN_MISALIGN_CHK_EN
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);
    assign w_mis  = |(w_target & LOW_MASK);
    assign w_load = w_target & ~LOW_MASK;
`else
    assign w_mis  = 1'b0;
    assign w_load = w_target;
`endif

    // a redirect overrides a same-cycle increment; the fired PC still counts as outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RST_PC;
            r_epoch     <= '0;
            r_pc_change <= 1'b1;
            r_misalign  <= 1'b0;
        end else if (w_src != SRC_NONE) begin
            r_pc        <= w_load;
            r_epoch     <= r_epoch + 1'b1;
            r_pc_change <= 1'b1;
            r_misalign  <= w_mis;
        end else begin
            r_pc        <= w_fire ? r_pc + XLEN'(INST_BYTES) : r_pc;
            r_pc_change <= w_fire;
            r_misalign  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb_ifu_pc_gen: directed test-plan sequences plus random traffic against an integer reference model.
module tb_ifu_pc_gen;
    localparam int MAX_OUTST = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic        trap_valid = 1'b0, BRANCH_PCSrc = 1'b0, fetch_ready = 1'b0, resp_valid = 1'b0;
    logic [31:0] trap_target = '0, BRANCH_branch_target = '0;
    logic        fetch_valid, pc_change, misalign_err;
    logic [31:0] IFU_o_pc;
    logic [1:0]  fetch_epoch;
    int n_vec = 0, n_err = 0;
    int unsigned m_pc;
    int m_epoch, m_outst;
    bit m_chg, m_mis;

    ifu_pc_gen #(.XLEN(32), .RST_PC(32'h8000_0000), .INST_BYTES(4), .EPOCH_W(2), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_target(trap_target),
        .BRANCH_PCSrc(BRANCH_PCSrc), .BRANCH_branch_target(BRANCH_branch_target),
        .fetch_ready(fetch_ready), .resp_valid(resp_valid), .fetch_valid(fetch_valid),
        .IFU_o_pc(IFU_o_pc), .fetch_epoch(fetch_epoch), .pc_change(pc_change), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pc = 32'h8000_0000; m_epoch = 0; m_outst = 0; m_chg = 1; m_mis = 0;
    endfunction

    task automatic chk_all();
        chk("fetch_valid", 64'(fetch_valid), 64'(m_outst != MAX_OUTST));
        chk("pc", 64'(IFU_o_pc), 64'(m_pc));
        chk("epoch", 64'(fetch_epoch), 64'(m_epoch));
        chk("pc_change", 64'(pc_change), 64'(m_chg));
        chk("misalign_err", 64'(misalign_err), 64'(m_mis));
    endtask

    task automatic cyc(input bit r, input bit tv, input logic [31:0] tt, input bit bv,
                       input logic [31:0] bt, input bit fr, input bit rv);
        bit fire;
        int unsigned tgt;
        rst = r; trap_valid = tv; trap_target = tt; BRANCH_PCSrc = bv;
        BRANCH_branch_target = bt; fetch_ready = fr; resp_valid = rv;
        fire = (m_outst != MAX_OUTST) && fr;
        if (r) m_reset();
        else begin
            m_outst = m_outst + int'(fire) - int'(rv && m_outst > 0);
            if (tv || bv) begin
                tgt = tv ? tt : bt;
`ifdef PC_GEN_MISALIGN_CHK_EN
                m_mis = (tgt % 4) != 0;
                tgt = tgt - tgt % 4;
`else
                m_mis = 0;
`endif
                m_pc = tgt; m_epoch = (m_epoch + 1) % 4; m_chg = 1;
            end else begin
                m_mis = 0; m_chg = fire;
                if (fire) m_pc = m_pc + 4;
            end
        end
        @(negedge clk);
        chk_all();
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", 64'(IFU_o_pc), 64'h8000_0000);
        chk("rst_fv", 64'(fetch_valid), 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("seq_pc1", 64'(IFU_o_pc), 64'h8000_0004);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("seq_pc2", 64'(IFU_o_pc), 64'h8000_0008);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("full_fv", 64'(fetch_valid), 64'd0);
        chk("full_pc", 64'(IFU_o_pc), 64'h8000_0008);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("drain_fv", 64'(fetch_valid), 64'd1);
        cyc(0, 0, 0, 1, 32'h8000_0100, 0, 0);
        chk("br_pc", 64'(IFU_o_pc), 64'h8000_0100);
        chk("br_epoch", 64'(fetch_epoch), 64'd1);
        cyc(0, 1, 32'h8000_0200, 1, 32'h8000_0100, 0, 0);
        chk("trap_pc", 64'(IFU_o_pc), 64'h8000_0200);
        chk("trap_epoch", 64'(fetch_epoch), 64'd2);
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("ep3", 64'(fetch_epoch), 64'd3);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("wrap_pc", 64'(IFU_o_pc), 64'h0);
        cyc(0, 0, 0, 1, 32'h8000_0102, 0, 0);
        chk("ep_wrap", 64'(fetch_epoch), 64'd0);
`ifdef PC_GEN_MISALIGN_CHK_EN
        chk("mis_pc", 64'(IFU_o_pc), 64'h8000_0100);
        chk("mis_err", 64'(misalign_err), 64'd1);
`else
        chk("mis_pc", 64'(IFU_o_pc), 64'h8000_0102);
        chk("mis_err", 64'(misalign_err), 64'd0);
`endif
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("mis_clr", 64'(misalign_err), 64'd0);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t0, t1;
            t0 = $urandom; t1 = $urandom;
            if ($urandom_range(1)) t0[1:0] = 2'b00;
            if ($urandom_range(1)) t1[1:0] = 2'b00;
            cyc($urandom_range(63) == 0, $urandom_range(7) == 0, t0, $urandom_range(7) == 0, t1,
                1'($urandom_range(1)), 1'($urandom_range(2) != 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
